// File: rtl/csr_regfile_if.sv
// CSR access bus between the pipeline and the machine-mode CSR file.
// Carries the MEM/WB write-back triple and the ID/EX combinational read port.
//   wb_csr_reg_we      : write enable from MEM/WB
//   wb_csr_reg_wr_addr : compact CSR index being written
//   wb_csr_reg_data    : write data
//   rd_addr            : compact CSR index being read
//   rd_data            : read data (combinational, with write-back bypass)
// master = pipeline side, slave = CSR file.
interface csr_regfile_if;
  logic        wb_csr_reg_we;
  logic [4:0]  wb_csr_reg_wr_addr;
  logic [31:0] wb_csr_reg_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  modport master (
    output wb_csr_reg_we, wb_csr_reg_wr_addr, wb_csr_reg_data, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wb_csr_reg_we, wb_csr_reg_wr_addr, wb_csr_reg_data, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage for the RV32I core.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause/mtval, exposes mip from the
// interrupt lines, and keeps the 64-bit mcycle and minstret counters.
// Performs trap-entry and MRET updates with priority trap > mret > CSR write.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   csr           : CSR bus (write-back triple + read port), slave side
//   instr_retire  : one instruction retired this cycle
//   trap_valid, trap_pc, trap_cause, trap_tval : trap entry request
//   mret_valid    : MRET retires this cycle
//   ext_irq, timer_irq, sw_irq : level interrupt inputs
//   mtvec_o, mepc_o : current trap vector / exception pc
//   irq_pending_o : mstatus.MIE & |(mie & mip)
module csr_regfile (
  input  logic          clk,
  input  logic          rst,
  csr_regfile_if.slave  csr,
  input  logic          instr_retire,
  input  logic          trap_valid,
  input  logic [31:0]   trap_pc,
  input  logic [31:0]   trap_cause,
  input  logic [31:0]   trap_tval,
  input  logic          mret_valid,
  input  logic          ext_irq,
  input  logic          timer_irq,
  input  logic          sw_irq,
  output logic [31:0]   mtvec_o,
  output logic [31:0]   mepc_o,
  output logic          irq_pending_o
);

  localparam logic [4:0] IDX_MSTATUS   = 5'd0;
  localparam logic [4:0] IDX_MIE       = 5'd1;
  localparam logic [4:0] IDX_MTVEC     = 5'd2;
  localparam logic [4:0] IDX_MSCRATCH  = 5'd3;
  localparam logic [4:0] IDX_MEPC      = 5'd4;
  localparam logic [4:0] IDX_MCAUSE    = 5'd5;
  localparam logic [4:0] IDX_MTVAL     = 5'd6;
  localparam logic [4:0] IDX_MIP       = 5'd7;
  localparam logic [4:0] IDX_MCYCLE    = 5'd8;
  localparam logic [4:0] IDX_MCYCLEH   = 5'd9;
  localparam logic [4:0] IDX_MINSTRET  = 5'd10;
  localparam logic [4:0] IDX_MINSTRETH = 5'd11;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  assign we = csr.wb_csr_reg_we;
  assign wa = csr.wb_csr_reg_wr_addr;
  assign wd = csr.wb_csr_reg_data;

  logic        mstatus_mie_reg;
  logic        mstatus_mpie_reg;
  logic [31:0] mie_reg;
  logic [31:0] mtvec_reg;
  logic [31:0] mscratch_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [31:0] mtval_reg;
  logic [63:0] mcycle_reg;
  logic [63:0] minstret_reg;

  logic [31:0] mstatus_val;
  logic [31:0] mip_val;
  logic [31:0] wr_val;
  logic [31:0] stored_val;
  logic        bypass;

  // MPP is hardwired to machine mode.
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};
  assign mip_val     = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, sw_irq, 3'b0};

  // Value a write would leave in the addressed register after field masking.
  always_comb begin
    wr_val = 32'h0;
    case (wa)
      IDX_MSTATUS:                     wr_val = (wd & 32'h0000_0088) | 32'h0000_1800;
      IDX_MIE:                         wr_val = wd & MIE_MASK;
      IDX_MTVEC, IDX_MEPC:             wr_val = {wd[31:2], 2'b00};
      IDX_MSCRATCH, IDX_MCAUSE, IDX_MTVAL,
      IDX_MCYCLE, IDX_MCYCLEH,
      IDX_MINSTRET, IDX_MINSTRETH:     wr_val = wd;
      default:                         wr_val = 32'h0;
    endcase
  end

  always_comb begin
    stored_val = 32'h0;
    case (csr.rd_addr)
      IDX_MSTATUS:   stored_val = mstatus_val;
      IDX_MIE:       stored_val = mie_reg;
      IDX_MTVEC:     stored_val = mtvec_reg;
      IDX_MSCRATCH:  stored_val = mscratch_reg;
      IDX_MEPC:      stored_val = mepc_reg;
      IDX_MCAUSE:    stored_val = mcause_reg;
      IDX_MTVAL:     stored_val = mtval_reg;
      IDX_MIP:       stored_val = mip_val;
      IDX_MCYCLE:    stored_val = mcycle_reg[31:0];
      IDX_MCYCLEH:   stored_val = mcycle_reg[63:32];
      IDX_MINSTRET:  stored_val = minstret_reg[31:0];
      IDX_MINSTRETH: stored_val = minstret_reg[63:32];
      default:       stored_val = 32'h0;
    endcase
  end

  // mip is read-only, so a write to it is never forwarded.
  assign bypass      = we && (wa == csr.rd_addr) && (wa <= IDX_MINSTRETH) && (wa != IDX_MIP);
  assign csr.rd_data = bypass ? wr_val : stored_val;

  assign mtvec_o       = mtvec_reg;
  assign mepc_o        = mepc_reg;
  assign irq_pending_o = mstatus_mie_reg & (|(mie_reg & mip_val));

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= 32'h0;
      mtvec_reg        <= 32'h0;
      mscratch_reg     <= 32'h0;
      mepc_reg         <= 32'h0;
      mcause_reg       <= 32'h0;
      mtval_reg        <= 32'h0;
      mcycle_reg       <= 64'h0;
      minstret_reg     <= 64'h0;
    end else begin
      // Trap and MRET each touch both mstatus fields, so they fully
      // shadow a concurrent mstatus write.
      if (trap_valid) begin
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (mret_valid) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (we && wa == IDX_MSTATUS) begin
        mstatus_mie_reg  <= wd[3];
        mstatus_mpie_reg <= wd[7];
      end

      if (trap_valid) begin
        mepc_reg   <= {trap_pc[31:2], 2'b00};
        mcause_reg <= trap_cause;
        mtval_reg  <= trap_tval;
      end else if (we) begin
        if (wa == IDX_MEPC)   mepc_reg   <= wr_val;
        if (wa == IDX_MCAUSE) mcause_reg <= wr_val;
        if (wa == IDX_MTVAL)  mtval_reg  <= wr_val;
      end

      if (we && wa == IDX_MIE)      mie_reg      <= wr_val;
      if (we && wa == IDX_MTVEC)    mtvec_reg    <= wr_val;
      if (we && wa == IDX_MSCRATCH) mscratch_reg <= wr_val;

      // A half write freezes the whole counter for that edge.
      if (we && wa == IDX_MCYCLE)
        mcycle_reg <= {mcycle_reg[63:32], wd};
      else if (we && wa == IDX_MCYCLEH)
        mcycle_reg <= {wd, mcycle_reg[31:0]};
      else
        mcycle_reg <= mcycle_reg + 64'd1;

      if (we && wa == IDX_MINSTRET)
        minstret_reg <= {minstret_reg[63:32], wd};
      else if (we && wa == IDX_MINSTRETH)
        minstret_reg <= {wd, minstret_reg[31:0]};
      else if (instr_retire)
        minstret_reg <= minstret_reg + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios followed by
// randomized traffic, both checked against a register-level reference model.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_retire;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        ext_irq;
  logic        timer_irq;
  logic        sw_irq;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        irq_pending_o;

  csr_regfile_if bus ();

  csr_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .csr           (bus.slave),
    .instr_retire  (instr_retire),
    .trap_valid    (trap_valid),
    .trap_pc       (trap_pc),
    .trap_cause    (trap_cause),
    .trap_tval     (trap_tval),
    .mret_valid    (mret_valid),
    .ext_irq       (ext_irq),
    .timer_irq     (timer_irq),
    .sw_irq        (sw_irq),
    .mtvec_o       (mtvec_o),
    .mepc_o        (mepc_o),
    .irq_pending_o (irq_pending_o)
  );

  always #50 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: registers 0..6 held as their full architectural read value.
  logic [31:0] m_csr [0:6];
  logic [63:0] m_cyc;
  logic [63:0] m_ins;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mip_now();
    return (32'(ext_irq) << 11) | (32'(timer_irq) << 7) | (32'(sw_irq) << 3);
  endfunction

  function automatic logic [31:0] post_mask(input int a, input logic [31:0] d);
    case (a)
      0:       return (d & 32'h88) | 32'h1800;
      1:       return d & 32'h888;
      2, 4:    return d & ~32'h3;
      3, 5, 6, 8, 9, 10, 11: return d;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] stored_read(input int a);
    if (a <= 6)  return m_csr[a];
    if (a == 7)  return mip_now();
    if (a == 8)  return m_cyc[31:0];
    if (a == 9)  return m_cyc[63:32];
    if (a == 10) return m_ins[31:0];
    if (a == 11) return m_ins[63:32];
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_read(input int a);
    int w;
    w = int'(bus.wb_csr_reg_wr_addr);
    if (bus.wb_csr_reg_we && w == a && a <= 11 && a != 7)
      return post_mask(a, bus.wb_csr_reg_data);
    return stored_read(a);
  endfunction

  function automatic logic exp_irq();
    return m_csr[0][3] && ((m_csr[1] & mip_now()) != 32'h0);
  endfunction

  // Next state: apply the CSR write, then mret, then trap, so higher
  // priority events overwrite what lower ones did to the same target.
  task automatic model_step();
    logic [31:0] old_ms;
    int w;
    logic cnt_written;
    logic ins_written;
    if (rst) begin
      m_csr[0] = 32'h1800;
      for (int i = 1; i <= 6; i++) m_csr[i] = 32'h0;
      m_cyc = 64'h0;
      m_ins = 64'h0;
      return;
    end
    old_ms = m_csr[0];
    w = int'(bus.wb_csr_reg_wr_addr);
    cnt_written = 1'b0;
    ins_written = 1'b0;
    if (bus.wb_csr_reg_we) begin
      if (w <= 6) m_csr[w] = post_mask(w, bus.wb_csr_reg_data);
      if (w == 8) begin m_cyc[31:0]  = bus.wb_csr_reg_data; cnt_written = 1'b1; end
      if (w == 9) begin m_cyc[63:32] = bus.wb_csr_reg_data; cnt_written = 1'b1; end
      if (w == 10) begin m_ins[31:0]  = bus.wb_csr_reg_data; ins_written = 1'b1; end
      if (w == 11) begin m_ins[63:32] = bus.wb_csr_reg_data; ins_written = 1'b1; end
    end
    if (!cnt_written) m_cyc = m_cyc + 1;
    if (!ins_written && instr_retire) m_ins = m_ins + 1;
    if (mret_valid)
      m_csr[0] = 32'h1800 | 32'h80 | (old_ms[7] ? 32'h8 : 32'h0);
    if (trap_valid) begin
      m_csr[0] = 32'h1800 | (old_ms[3] ? 32'h80 : 32'h0);
      m_csr[4] = trap_pc & ~32'h3;
      m_csr[5] = trap_cause;
      m_csr[6] = trap_tval;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0;
    bus.wb_csr_reg_we = 1'b0;
    bus.wb_csr_reg_wr_addr = 5'd0;
    bus.wb_csr_reg_data = 32'h0;
    bus.rd_addr = 5'd0;
    instr_retire = 1'b0;
    trap_valid = 1'b0;
    trap_pc = 32'h0;
    trap_cause = 32'h0;
    trap_tval = 32'h0;
    mret_valid = 1'b0;
    ext_irq = 1'b0;
    timer_irq = 1'b0;
    sw_irq = 1'b0;
  endtask

  task automatic csr_write(input int a, input logic [31:0] d);
    bus.wb_csr_reg_we = 1'b1;
    bus.wb_csr_reg_wr_addr = a[4:0];
    bus.wb_csr_reg_data = d;
    $display("write idx %0d = %08h", a, d);
  endtask

  task automatic rd_check(input string tag, input int a, input logic [31:0] exp);
    bus.rd_addr = a[4:0];
    #1;
    check(tag, bus.rd_data, exp);
    $display("read  idx %0d -> %08h (%s)", a, bus.rd_data, tag);
  endtask

  // Compare every mapped index against the model (call with writes idle).
  task automatic check_all(input string tag);
    for (int a = 0; a < 12; a++) begin
      bus.rd_addr = a[4:0];
      #1;
      check($sformatf("%s_rd%0d", tag, a), bus.rd_data, exp_read(a));
    end
    check({tag, "_mtvec"}, mtvec_o, m_csr[2]);
    check({tag, "_mepc"}, mepc_o, m_csr[4]);
    check({tag, "_irq"}, 32'(irq_pending_o), 32'(exp_irq()));
  endtask

  initial begin
    for (int i = 0; i <= 6; i++) m_csr[i] = 32'h0;
    m_cyc = 64'h0;
    m_ins = 64'h0;
    set_idle();
    rst = 1'b1;
    #1;

    // Reset state
    tick();
    tick();
    check("rst_mtvec", mtvec_o, 32'h0);
    check("rst_mepc", mepc_o, 32'h0);
    check("rst_irq", 32'(irq_pending_o), 32'h0);
    rst = 1'b0;
    repeat (5) tick();
    rd_check("idle_mstatus", 0, 32'h0000_1800);
    rd_check("idle_mcycle", 8, 32'd5);
    rd_check("idle_mcycleh", 9, 32'd0);

    // mtvec write with same-cycle bypass
    csr_write(2, 32'h8000_0103);
    rd_check("mtvec_bypass", 2, 32'h8000_0100);
    tick();
    set_idle();
    check("mtvec_o", mtvec_o, 32'h8000_0100);

    // Trap entry and MRET
    csr_write(0, 32'hFFFF_FFFF);
    tick();
    set_idle();
    trap_valid = 1'b1;
    trap_pc = 32'h0000_0206;
    trap_cause = 32'h8000_000B;
    $display("trap pc %08h cause %08h", trap_pc, trap_cause);
    tick();
    set_idle();
    rd_check("trap_mepc", 4, 32'h0000_0204);
    rd_check("trap_mcause", 5, 32'h8000_000B);
    rd_check("trap_mstatus", 0, 32'h0000_1880);
    mret_valid = 1'b1;
    $display("mret");
    tick();
    set_idle();
    rd_check("mret_mstatus", 0, 32'h0000_1888);

    // minstret carry into high word
    csr_write(10, 32'hFFFF_FFFF);
    tick();
    csr_write(11, 32'h0000_0001);
    tick();
    set_idle();
    instr_retire = 1'b1;
    $display("retire x2");
    tick();
    tick();
    set_idle();
    rd_check("minstret", 10, 32'h0000_0001);
    rd_check("minstreth", 11, 32'h0000_0002);

    // Interrupt pending, cleared by trap entry
    csr_write(1, 32'h0000_0880);
    tick();
    csr_write(0, 32'h0000_0008);
    tick();
    set_idle();
    timer_irq = 1'b1;
    #1;
    check("irq_timer", 32'(irq_pending_o), 32'h1);
    trap_valid = 1'b1;
    trap_pc = 32'h0000_0100;
    tick();
    trap_valid = 1'b0;
    #1;
    check("irq_after_trap", 32'(irq_pending_o), 32'h0);
    set_idle();

    // Trap concurrent with CSR writes
    trap_valid = 1'b1;
    trap_pc = 32'h0000_0300;
    csr_write(4, 32'h0000_1234);
    tick();
    set_idle();
    rd_check("trap_wins_mepc", 4, 32'h0000_0300);
    trap_valid = 1'b1;
    trap_pc = 32'h0000_0400;
    csr_write(3, 32'h0000_005A);
    tick();
    set_idle();
    rd_check("trap_mscratch", 3, 32'h0000_005A);
    rd_check("trap2_mepc", 4, 32'h0000_0400);

    // Unmapped index
    csr_write(20, 32'hFFFF_FFFF);
    rd_check("unmapped_bypass", 20, 32'h0);
    tick();
    set_idle();
    rd_check("unmapped_read", 20, 32'h0);
    check_all("post_unmapped");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int ra;
      rst = ($urandom_range(0, 299) == 0);
      bus.wb_csr_reg_we = 1'($urandom_range(0, 1));
      bus.wb_csr_reg_wr_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                           : 5'($urandom_range(0, 11));
      bus.wb_csr_reg_data = $urandom;
      instr_retire = 1'($urandom_range(0, 1));
      trap_valid = ($urandom_range(0, 9) == 0);
      mret_valid = ($urandom_range(0, 9) == 0);
      trap_pc = $urandom;
      trap_cause = $urandom;
      trap_tval = $urandom;
      ext_irq = 1'($urandom_range(0, 1));
      timer_irq = 1'($urandom_range(0, 1));
      sw_irq = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 1) == 0) ? int'(bus.wb_csr_reg_wr_addr) : int'($urandom_range(0, 15));
      bus.rd_addr = ra[4:0];
      #1;
      check($sformatf("rand%0d_rd%0d", n, ra), bus.rd_data, exp_read(ra));
      check($sformatf("rand%0d_mtvec", n), mtvec_o, m_csr[2]);
      check($sformatf("rand%0d_mepc", n), mepc_o, m_csr[4]);
      check($sformatf("rand%0d_irq", n), 32'(irq_pending_o), 32'(exp_irq()));
      tick();
    end
    set_idle();
    #1;
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
